pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central controller for the five-stage pipeline: drives the write enables and bubble/flush strobes of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline register banks and the PC.
- Resolves load-use hazards, taken-branch squashes and data-memory wait states with a fixed priority.
- Runs a memory-wait watchdog that halts the pipe on timeout.
- Keeps saturating stall and flush counters for performance debug.
- Sits beside the datapath; every pipeline register bank's wrEn comes from here.

## Interface
- MEM_TIMEOUT, 16: wait cycles tolerated in MEM_WAIT before HALT (≥1)
- CNT_W, 32: width of performance counters
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- id_Rn, id_Rm  in  5 each  source registers of instruction in ID
- id_rn_used, id_rm_used  in  1 each  ID instruction actually reads Rn/Rm
- ex_load  in  1  instruction in EX is a load
- ex_Rd  in  5  destination of EX instruction
- ex_brTaken  in  1  branch in EX resolved taken
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_wrEn, ifid_wrEn, idex_wrEn, exmem_wrEn, memwb_wrEn  out  1 each  register-bank enables
- ifid_flush, idex_bubble  out  1 each  load NOP/zeroed controls into IF/ID, ID/EX
- halted  out  1  pipeline stopped by watchdog
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- States: RUN, MEM_WAIT, HALT. Reset → RUN.
- Freeze condition F = mem_req & !mem_ready. Flush condition B = ex_brTaken. Load-use L = ex_load & ex_Rd≠31 & ((id_rn_used & id_Rn==ex_Rd) | (id_rm_used & id_Rm==ex_Rd)). Register 31 (XZR) never creates a hazard.
- Priority F > B > L, evaluated in RUN and MEM_WAIT:
  - F: all five wrEn=0, flush/bubble=0. RUN→MEM_WAIT; in MEM_WAIT the wait counter increments.
  - B: all wrEn=1, ifid_flush=1, idex_bubble=1; PC loads the branch target. L is ignored because the dependent instruction is squashed.
  - L: pc_wrEn=0, ifid_wrEn=0, idex_bubble=1, idex_wrEn/exmem_wrEn/memwb_wrEn=1.
  - None: all wrEn=1, strobes 0.
- MEM_WAIT: on mem_ready, return to RUN and apply the B/L/none rule that same cycle. A held branch therefore flushes on the release cycle.
  - Wait counter reset: 0 on entry to MEM_WAIT and on exit from it.
  - Timeout: if the counter reaches MEM_TIMEOUT with F still true, go to HALT.
- HALT: all wrEn=0, strobes 0, halted=1. Exit only via reset.
- stall_cnt: +1 every cycle pc_wrEn=0 outside reset, including HALT. Saturates at all-ones.
- flush_cnt: +1 every cycle ifid_flush=1 (branch flushes only). Saturates.

## Timing
- Enables and strobes are combinational from current state and inputs. They settle the same cycle and are sampled by the register banks at the next rising edge.
- State, wait counter and perf counters are registered and update on the rising edge.
- Reset values (asynchronous, while reset=0): state RUN, wait counter 0, stall_cnt 0, flush_cnt 0, halted 0. All wrEn and strobes are forced to 0 while reset=0.
- Load-use costs exactly 1 bubble per hazard. Taken branch costs 2 squashed slots. Memory wait costs one frozen cycle per cycle mem_ready is low.
- F held N < MEM_TIMEOUT cycles: N frozen cycles, then normal. F held MEM_TIMEOUT cycles: halted=1 from the next edge.
- Reset deasserted mid-wait: restart in RUN with counters cleared; no pending flush is remembered.

## Structure
- Package pipeline_ctrl_pkg holds:
  - state enum (RUN, MEM_WAIT, HALT) as a 2-bit logic typedef
  - XZR constant = 5'd31
  - default MEM_TIMEOUT
- Sub-module hazard_detect: purely combinational L-condition compare, reusable for a later forwarding unit.
- Counters and FSM live in pipeline_sequencer.

## Test plan
- Load-use: ex_load=1, ex_Rd=3, id_Rn=3, id_rn_used=1 → pc_wrEn=0, ifid_wrEn=0, idex_bubble=1; stall_cnt 0→1. Repeat with ex_Rd=31 → no stall.
- Branch + hazard: ex_brTaken=1 together with the load-use condition → ifid_flush=1, idex_bubble=1, pc_wrEn=1; flush_cnt +1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → all wrEn=0 for 3 cycles, state MEM_WAIT; release cycle all wrEn=1; stall_cnt=3.
- Wait + branch: ex_brTaken=1 held during a 2-cycle wait → no flush while frozen; flush occurs on the mem_ready cycle; flush_cnt=1.
- Watchdog: MEM_TIMEOUT=4, mem_ready held 0 → halted=1 after 4 MEM_WAIT cycles; enables stay 0 for 10 further cycles. Pulse reset low → halted=0, counters 0, state RUN.
- Saturation: CNT_W=3, hold a stall source for 10 cycles → stall_cnt sticks at 7.

Source files
------------

// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline sequencer and its hazard logic.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } seq_state_t;

    localparam logic [4:0] XZR                 = 5'd31;
    localparam int         DEFAULT_MEM_TIMEOUT = 16;
    localparam int         DEFAULT_CNT_W       = 32;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Hazard/memory status from the datapath and the bank enables back to it.
interface pipeline_sequencer_if;

    logic [4:0] id_Rn;
    logic [4:0] id_Rm;
    logic       id_rn_used;
    logic       id_rm_used;
    logic       ex_load;
    logic [4:0] ex_Rd;
    logic       ex_brTaken;
    logic       mem_req;
    logic       mem_ready;

    logic       pc_wrEn;
    logic       ifid_wrEn;
    logic       idex_wrEn;
    logic       exmem_wrEn;
    logic       memwb_wrEn;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       halted;

    modport master (
        output id_Rn, id_Rm, id_rn_used, id_rm_used, ex_load, ex_Rd,
               ex_brTaken, mem_req, mem_ready,
        input  pc_wrEn, ifid_wrEn, idex_wrEn, exmem_wrEn, memwb_wrEn,
               ifid_flush, idex_bubble, halted
    );

    modport slave (
        input  id_Rn, id_Rm, id_rn_used, id_rm_used, ex_load, ex_Rd,
               ex_brTaken, mem_req, mem_ready,
        output pc_wrEn, ifid_wrEn, idex_wrEn, exmem_wrEn, memwb_wrEn,
               ifid_flush, idex_bubble, halted
    );

endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Combinational load-use detector: EX load whose destination feeds the ID instruction.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_Rn,
    input  logic [4:0] id_Rm,
    input  logic       id_rn_used,
    input  logic       id_rm_used,
    input  logic       ex_load,
    input  logic [4:0] ex_Rd,
    output logic       load_use
);

    // XZR reads as zero, so a load "into" it never produces a real dependency.
    assign load_use = ex_load && (ex_Rd != XZR) &&
                      ((id_rn_used && (id_Rn == ex_Rd)) ||
                       (id_rm_used && (id_Rm == ex_Rd)));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline controller: freeze > branch flush > load-use bubble, memory watchdog
// and saturating stall/flush performance counters.
module pipeline_sequencer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_W       = DEFAULT_CNT_W
)
(
    input  logic             clk,
    input  logic             reset,
    pipeline_sequencer_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    seq_state_t    state;
    seq_state_t    stateNext;
    logic [WW-1:0] waitCnt;
    logic [WW-1:0] waitCntNext;

    logic loadUse;
    logic freeze;
    logic pcWrEn;
    logic ifidWrEn;
    logic idexWrEn;
    logic exmemWrEn;
    logic memwbWrEn;
    logic ifidFlush;
    logic idexBubble;

    hazard_detect u_hazard_detect (
        .id_Rn      (bus.id_Rn),
        .id_Rm      (bus.id_Rm),
        .id_rn_used (bus.id_rn_used),
        .id_rm_used (bus.id_rm_used),
        .ex_load    (bus.ex_load),
        .ex_Rd      (bus.ex_Rd),
        .load_use   (loadUse)
    );

    assign freeze = bus.mem_req && !bus.mem_ready;

    // The entry cycle counts as the first frozen cycle, so MEM_WAIT halts
    // once the wait counter shows MEM_TIMEOUT-2 further frozen cycles.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        pcWrEn      = 1'b0;
        ifidWrEn    = 1'b0;
        idexWrEn    = 1'b0;
        exmemWrEn   = 1'b0;
        memwbWrEn   = 1'b0;
        ifidFlush   = 1'b0;
        idexBubble  = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                if (freeze) begin
                    if (state == RUN) begin
                        waitCntNext = '0;
                        if (MEM_TIMEOUT <= 1) begin
                            stateNext = HALT;
                        end else begin
                            stateNext = MEM_WAIT;
                        end
                    end else if (int'(waitCnt) >= MEM_TIMEOUT - 2) begin
                        stateNext   = HALT;
                        waitCntNext = '0;
                    end else begin
                        waitCntNext = waitCnt + WW'(1);
                    end
                end else begin
                    stateNext   = RUN;
                    waitCntNext = '0;
                    pcWrEn      = 1'b1;
                    ifidWrEn    = 1'b1;
                    idexWrEn    = 1'b1;
                    exmemWrEn   = 1'b1;
                    memwbWrEn   = 1'b1;
                    if (bus.ex_brTaken) begin
                        ifidFlush  = 1'b1;
                        idexBubble = 1'b1;
                    end else if (loadUse) begin
                        pcWrEn     = 1'b0;
                        ifidWrEn   = 1'b0;
                        idexBubble = 1'b1;
                    end
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext   = RUN;
                waitCntNext = '0;
            end
        endcase
        if (!reset) begin
            pcWrEn     = 1'b0;
            ifidWrEn   = 1'b0;
            idexWrEn   = 1'b0;
            exmemWrEn  = 1'b0;
            memwbWrEn  = 1'b0;
            ifidFlush  = 1'b0;
            idexBubble = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            waitCnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (!pcWrEn && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ifidFlush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_wrEn     = pcWrEn;
    assign bus.ifid_wrEn   = ifidWrEn;
    assign bus.idex_wrEn   = idexWrEn;
    assign bus.exmem_wrEn  = exmemWrEn;
    assign bus.memwb_wrEn  = memwbWrEn;
    assign bus.ifid_flush  = ifidFlush;
    assign bus.idex_bubble = idexBubble;
    assign bus.halted      = (state == HALT);

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Drives two sequencers (32-bit and 3-bit counters) with shared stimulus and
// checks both against a cycle-level behavioural model of the control rules.
module tb_pipeline_sequencer;

    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_Rn;
    logic [4:0] id_Rm;
    logic       id_rn_used;
    logic       id_rm_used;
    logic       ex_load;
    logic [4:0] ex_Rd;
    logic       ex_brTaken;
    logic       mem_req;
    logic       mem_ready;

    logic [31:0] stallA;
    logic [31:0] flushA;
    logic [2:0]  stallB;
    logic [2:0]  flushB;

    int compared   = 0;
    int mismatched = 0;

    pipeline_sequencer_if busA ();
    pipeline_sequencer_if busB ();

    assign busA.id_Rn      = id_Rn;
    assign busA.id_Rm      = id_Rm;
    assign busA.id_rn_used = id_rn_used;
    assign busA.id_rm_used = id_rm_used;
    assign busA.ex_load    = ex_load;
    assign busA.ex_Rd      = ex_Rd;
    assign busA.ex_brTaken = ex_brTaken;
    assign busA.mem_req    = mem_req;
    assign busA.mem_ready  = mem_ready;
    assign busB.id_Rn      = id_Rn;
    assign busB.id_Rm      = id_Rm;
    assign busB.id_rn_used = id_rn_used;
    assign busB.id_rm_used = id_rm_used;
    assign busB.ex_load    = ex_load;
    assign busB.ex_Rd      = ex_Rd;
    assign busB.ex_brTaken = ex_brTaken;
    assign busB.mem_req    = mem_req;
    assign busB.mem_ready  = mem_ready;

    pipeline_sequencer #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(32)) dutA (
        .clk       (clk),
        .reset     (reset),
        .bus       (busA),
        .stall_cnt (stallA),
        .flush_cnt (flushA)
    );

    pipeline_sequencer #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(3)) dutB (
        .clk       (clk),
        .reset     (reset),
        .bus       (busB),
        .stall_cnt (stallB),
        .flush_cnt (flushB)
    );

    // Control vectors packed as {pc, ifid, idex, exmem, memwb, ifid_flush, idex_bubble}.
    logic [6:0] ctrlA;
    logic [6:0] ctrlB;
    assign ctrlA = {busA.pc_wrEn, busA.ifid_wrEn, busA.idex_wrEn, busA.exmem_wrEn,
                    busA.memwb_wrEn, busA.ifid_flush, busA.idex_bubble};
    assign ctrlB = {busB.pc_wrEn, busB.ifid_wrEn, busB.idex_wrEn, busB.exmem_wrEn,
                    busB.memwb_wrEn, busB.ifid_flush, busB.idex_bubble};

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rn, input logic [4:0] rm,
                                 input logic rnU, input logic rmU,
                                 input logic ld, input logic [4:0] rd,
                                 input logic br, input logic req, input logic rdy);
        @(posedge clk);
        #1;
        id_Rn      = rn;
        id_Rm      = rm;
        id_rn_used = rnU;
        id_rm_used = rmU;
        ex_load    = ld;
        ex_Rd      = rd;
        ex_brTaken = br;
        mem_req    = req;
        mem_ready  = rdy;
    endtask

    task automatic setIdle();
        id_Rn      = 5'd0;
        id_Rm      = 5'd0;
        id_rn_used = 1'b0;
        id_rm_used = 1'b0;
        ex_load    = 1'b0;
        ex_Rd      = 5'd0;
        ex_brTaken = 1'b0;
        mem_req    = 1'b0;
        mem_ready  = 1'b0;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        setIdle();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [4:0] pickReg();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    // Behavioural model: halted flag, run length of consecutive frozen cycles,
    // and unbounded stall/flush totals clipped to each counter's width.
    bit         mHalted    = 1'b0;
    int         mFreezeRun = 0;
    int         stallTot   = 0;
    int         flushTot   = 0;
    logic [6:0] mCtrl;
    bit         mFreeze;
    bit         mLoadUse;

    always @(negedge clk) begin
        if (!reset) begin
            mHalted    = 1'b0;
            mFreezeRun = 0;
            stallTot   = 0;
            flushTot   = 0;
            checkOutput("rst ctrlA", 32'(ctrlA), 32'd0);
            checkOutput("rst ctrlB", 32'(ctrlB), 32'd0);
            checkOutput("rst haltedA", 32'(busA.halted), 32'd0);
            checkOutput("rst stallA", stallA, 32'd0);
            checkOutput("rst flushB", 32'(flushB), 32'd0);
        end else begin
            mFreeze  = mem_req && !mem_ready;
            mLoadUse = ex_load && (ex_Rd != 5'd31) &&
                       ((id_rn_used && id_Rn == ex_Rd) || (id_rm_used && id_Rm == ex_Rd));
            if (mHalted || mFreeze) begin
                mCtrl = 7'b0000000;
            end else if (ex_brTaken) begin
                mCtrl = 7'b1111111;
            end else if (mLoadUse) begin
                mCtrl = 7'b0011101;
            end else begin
                mCtrl = 7'b1111100;
            end
            checkOutput("model ctrlA", 32'(ctrlA), 32'(mCtrl));
            checkOutput("model ctrlB", 32'(ctrlB), 32'(mCtrl));
            checkOutput("model haltedA", 32'(busA.halted), 32'(mHalted));
            checkOutput("model haltedB", 32'(busB.halted), 32'(mHalted));
            checkOutput("model stallA", stallA, 32'(stallTot));
            checkOutput("model flushA", flushA, 32'(flushTot));
            checkOutput("model stallB", 32'(stallB), (stallTot > 7) ? 32'd7 : 32'(stallTot));
            checkOutput("model flushB", 32'(flushB), (flushTot > 7) ? 32'd7 : 32'(flushTot));
            if (!mCtrl[6]) stallTot++;
            if (mCtrl[1]) flushTot++;
            if (!mHalted) begin
                if (mFreeze) begin
                    mFreezeRun++;
                    if (mFreezeRun >= TIMEOUT) mHalted = 1'b1;
                end else begin
                    mFreezeRun = 0;
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        setIdle();
        @(negedge clk);
        checkOutput("reset ctrlA", 32'(ctrlA), 32'd0);
        checkOutput("reset flushA", flushA, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Load-use on Rn, then the same with XZR as destination.
        applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("lu ctrl", 32'(ctrlA), 32'b0011101);
        checkOutput("lu stall before", stallA, 32'd0);
        applyStimulus(5'd31, 5'd0, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("xzr ctrl", 32'(ctrlA), 32'b1111100);
        checkOutput("lu stall after", stallA, 32'd1);

        // Branch together with a load-use: branch wins.
        applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("br+lu ctrl", 32'(ctrlA), 32'b1111111);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("br flush cnt", flushA, 32'd1);
        checkOutput("br stall cnt", stallA, 32'd1);

        // Three-cycle memory wait, then release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("wait ctrl", 32'(ctrlA), 32'd0);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("release ctrl", 32'(ctrlA), 32'b1111100);

        // Branch held through a two-cycle wait flushes only on release.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("wait+br ctrl", 32'(ctrlA), 32'd0);
            if (i == 0) checkOutput("wait stall cnt", stallA, 32'd4);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("wait+br release", 32'(ctrlA), 32'b1111111);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("wait+br flush cnt", flushA, 32'd2);
        checkOutput("wait+br stall cnt", stallA, 32'd6);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulseReset();
            end else begin
                applyStimulus(pickReg(), pickReg(), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              pickReg(), ($urandom_range(0, 3) == 0),
                              1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
            end
        end

        // Watchdog: four frozen cycles halt the pipe, and it stays halted.
        pulseReset();
        for (int i = 0; i < TIMEOUT; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("wd not halted", 32'(busA.halted), 32'd0);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
            @(negedge clk);
            checkOutput("wd halted", 32'(busA.halted), 32'd1);
            checkOutput("wd ctrl", 32'(ctrlA), 32'd0);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("wd stallA", stallA, 32'd14);
        checkOutput("sat stallB", 32'(stallB), 32'd7);
        checkOutput("wd flushA", flushA, 32'd0);

        pulseReset();
        @(negedge clk);
        checkOutput("post-rst halted", 32'(busA.halted), 32'd0);
        checkOutput("post-rst stall", stallA, 32'd0);
        checkOutput("post-rst ctrl", 32'(ctrlA), 32'b1111100);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
